// File: rtl/calc_pkg.sv
// Shared key codes, FSM state type and default digit limit for the calculator operand entry block.
package calc_pkg;

  localparam int CALC_MAX_DIGITS = 3;

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_MINUS = 4'hB;
  localparam logic [3:0] KEY_EQ    = 4'hC;
  localparam logic [3:0] KEY_CLR   = 4'hD;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    DONE    = 2'd2
  } calc_state_e;

endpackage

// File: rtl/calc_digit_accum.sv
// Decimal digit accumulator: proposes acc*10+digit and says whether it may be taken
// (digit budget not exhausted and the result still fits in 8 bits).
module calc_digit_accum #(
  parameter int CNT_W      = 2,
  parameter int MAX_DIGITS = 3
) (
  input  logic [7:0]       acc_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [3:0]       digit_i,
  output logic [7:0]       acc_o,
  output logic             accept_o
);

  // 12 bits holds the worst case 255*10+9 without wrapping.
  logic [11:0] new_val;

  assign new_val  = 12'(acc_i) * 12'd10 + 12'(digit_i);
  assign acc_o    = new_val[7:0];
  assign accept_o = (count_i < CNT_W'(MAX_DIGITS)) && (new_val <= 12'd255);

endmodule

// File: rtl/calc_operand_entry.sv
// Keypad operand sequencer in front of the 8-bit adder/subtractor; DONE feeds the adder
// result back as operand A so operations can be chained.
//
// state   | meaning
// ENTER_A | collecting digits of operand A
// ENTER_B | operator captured, collecting digits of operand B
// DONE    | operands held, adder result valid and displayed
module calc_operand_entry
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = CALC_MAX_DIGITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [7:0] result_in,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       m,
  output logic       result_valid,
  output logic       calc_start,
  output logic [7:0] display_val,
  output logic       key_reject
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  calc_state_e      state_q, state_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic             m_q, m_d, start_q, start_d, reject_q, reject_d;

  logic [7:0]       acc_sel, acc_nxt;
  logic [CNT_W-1:0] cnt_sel;
  logic             accept;
  logic             is_digit, is_op, op_sub;

  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code == KEY_PLUS) || (key_code == KEY_MINUS);
  assign op_sub   = (key_code == KEY_MINUS);

  // One accumulator shared by both operands; only the entry state's operand is fed in.
  assign acc_sel = (state_q == ENTER_B) ? b_q : a_q;
  assign cnt_sel = (state_q == ENTER_B) ? b_cnt_q : a_cnt_q;

  calc_digit_accum #(
    .CNT_W      (CNT_W),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_accum (
    .acc_i    (acc_sel),
    .count_i  (cnt_sel),
    .digit_i  (key_code),
    .acc_o    (acc_nxt),
    .accept_o (accept)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ENTER_A;
      a_q      <= '0;
      b_q      <= '0;
      a_cnt_q  <= '0;
      b_cnt_q  <= '0;
      m_q      <= 1'b0;
      start_q  <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_cnt_q  <= a_cnt_d;
      b_cnt_q  <= b_cnt_d;
      m_q      <= m_d;
      start_q  <= start_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    a_cnt_d  = a_cnt_q;
    b_cnt_d  = b_cnt_q;
    m_d      = m_q;
    start_d  = 1'b0;
    reject_d = 1'b0;

    if (key_valid) begin
      case (state_q)
        ENTER_A: begin
          if (is_digit) begin
            if (accept) begin
              a_d     = acc_nxt;
              a_cnt_d = a_cnt_q + CNT_W'(1);
            end else begin
              reject_d = 1'b1;
            end
          end else if (is_op) begin
            m_d     = op_sub;
            b_d     = '0;
            b_cnt_d = '0;
            state_d = ENTER_B;
          end else if (key_code == KEY_EQ) begin
            reject_d = 1'b1;
          end else if (key_code == KEY_CLR) begin
            a_d     = '0;
            a_cnt_d = '0;
            m_d     = 1'b0;
          end
        end

        ENTER_B: begin
          if (is_digit) begin
            if (accept) begin
              b_d     = acc_nxt;
              b_cnt_d = b_cnt_q + CNT_W'(1);
            end else begin
              reject_d = 1'b1;
            end
          end else if (is_op) begin
            if (b_cnt_q == '0) m_d = op_sub;
            else reject_d = 1'b1;
          end else if (key_code == KEY_EQ) begin
            start_d = 1'b1;
            state_d = DONE;
          end else if (key_code == KEY_CLR) begin
            a_d     = '0;
            b_d     = '0;
            a_cnt_d = '0;
            b_cnt_d = '0;
            m_d     = 1'b0;
            state_d = ENTER_A;
          end
        end

        DONE: begin
          if (is_digit) begin
            a_d     = {4'b0000, key_code};
            a_cnt_d = CNT_W'(1);
            b_d     = '0;
            b_cnt_d = '0;
            m_d     = 1'b0;
            state_d = ENTER_A;
          end else if (is_op) begin
            // Chained operand is already "full", so stray digits cannot extend it.
            a_d     = result_in;
            a_cnt_d = CNT_W'(MAX_DIGITS);
            b_d     = '0;
            b_cnt_d = '0;
            m_d     = op_sub;
            state_d = ENTER_B;
          end else if (key_code == KEY_EQ) begin
            reject_d = 1'b1;
          end else if (key_code == KEY_CLR) begin
            a_d     = '0;
            b_d     = '0;
            a_cnt_d = '0;
            b_cnt_d = '0;
            m_d     = 1'b0;
            state_d = ENTER_A;
          end
        end

        default: state_d = ENTER_A;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      ENTER_B: display_val = b_q;
      DONE:    display_val = result_in;
      default: display_val = a_q;
    endcase
  end

  assign op_a         = a_q;
  assign op_b         = b_q;
  assign m            = m_q;
  assign result_valid = (state_q == DONE);
  assign calc_start   = start_q;
  assign key_reject   = reject_q;

endmodule
